rat_regfile: RTL and testbench
==============================

Name: rat_regfile

Overview:
- Architectural register file fused with the register alias table.
- Consumer end of the ROB issue/commit interface: takes issue-time renames (write_rat, tag, dest) and the up-to-two in-order commits per cycle (commit1/commit2, addr, val, tag).
- Gives the dispatch stage two source operands, each either a committed value or a ROB tag to wait on.

Parameters:
- NREG, 32, architectural registers (r0 hardwired zero)
- TAG_W, 5, ROB tag width (ROB depth 32)
- DATA_W, 32, register width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- write_rat  in  1  issue is renaming a destination this cycle
- issue_dest  in  5  destination register of issuing instruction
- issue_tag  in  TAG_W  ROB tag allocated to it
- commit1  in  1  first (older) commit valid
- commit_addr  in  5  first commit register
- commit_val  in  DATA_W  first commit value
- commit_tag  in  TAG_W  ROB tag of first commit
- commit2  in  1  second (younger) commit valid
- commit_addr2  in  5  second commit register
- commit_val2  in  DATA_W  second commit value
- commit_tag2  in  TAG_W  ROB tag of second commit
- flush  in  1  discard all renames (recovery)
- rs_addr, rt_addr  in  5 each  source operand registers
- rs_val, rt_val  out  DATA_W each  committed (or bypassed) value
- rs_tag, rt_tag  out  TAG_W each  pending ROB tag
- rs_ready, rt_ready  out  1 each  1 = value valid, 0 = wait on tag

Behaviour:
- State:
  - regs[32] x DATA_W
  - busy[32] x 1
  - map[32] x TAG_W
- Reset (rst low, asynchronous):
  - all regs, busy and map cleared.
  - Outputs then read value 0, ready 1, tag 0 for any address.
- Issue (posedge, write_rat=1, issue_dest!=0): busy[dest]<=1, map[dest]<=issue_tag. Dest 0 is ignored.
- Commit (posedge): commit1 writes regs[commit_addr], then commit2 writes regs[commit_addr2]. Address 0 is never written.
- Same register in both commits: commit2's value wins.
- Busy clear on commit: busy[a]<=0 only if busy[a]=1 and map[a]==that commit's tag. A younger rename stays live.
- Issue and commit to the same register in one cycle: issue wins, so busy=1 and map=issue_tag. The commit value is still written to regs.
- Both commits plus an issue all on one register: the RF gets commit_val2, and the rename table takes the issue.
- flush: all busy<=0 at posedge; regs unaffected. flush together with write_rat: the issue rename still lands.
- Read ports (combinational, zero latency), in priority order:
  1. Address 0 → val 0, ready 1, tag 0.
  2. Not busy → regs value, ready 1, tag 0.
  3. Busy and a same-cycle commit tag == map[a] → bypass that commit's value, ready 1. If both commits match, commit2 wins.
  4. Otherwise → ready 0, tag = map[a], val = regs[a] (don't-care).
- Same-cycle issue is not visible to reads; the dispatcher handles intra-group dependencies.
- Reset mid-operation: all state cleared immediately, independent of clk.

Decomposition:
- Shared package holds:
  - TAG_W, DATA_W, NREG
  - REG_ZERO=0, REG_RA=31
  - a rename-entry typedef {busy, tag}
- Natural sub-module: rat_read_port, the combinational lookup plus commit bypass, instantiated twice (rs, rt).
- The RF/table update logic stays in the top module.

Test Plan:
- Reset, then read r5 → rs_val=0, rs_ready=1. Write r0 via commit (val 0xFFFF) → r0 still reads 0.
- Issue r3 tag 7; read r3 → ready=0, tag=7. Next cycle commit r3 val 0xAB tag 7, reading r3 in the same cycle → bypass 0xAB, ready 1. After the edge → regs[3]=0xAB, busy clear.
- Issue r4 tag 2, then r4 tag 9. Commit r4 tag 2 val 0x11 → regs[4]=0x11, r4 still ready=0, tag=9.
- Commit1 r6 val 1 and commit2 r6 val 2 in the same cycle → regs[6]=2.
- Issue r8 tag 4 and commit r8 tag 4 val 0x55 in the same cycle → regs[8]=0x55, busy=1, tag=4.
- Issue r10 tag 12, flush → r10 reads ready=1 with its old value. Assert rst low mid-cycle → all reads return 0/ready immediately.

Source files
------------

// File: rtl/rat_regfile_pkg.sv
// Shared types and constants for the architectural register file / rename table.
package rat_regfile_pkg;

   localparam int NREG   = 32;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int AREG_W = $clog2(NREG);

   typedef logic [AREG_W-1:0] areg_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam areg_t REG_ZERO = areg_t'(0);
   localparam areg_t REG_RA   = areg_t'(31);

   typedef struct packed {
      logic busy;
      tag_t tag;
   } rat_entry_t;

endpackage

// File: rtl/rat_regfile_if.sv
// Issue/commit/flush/read bundle between the ROB-side producers and the register file.
interface rat_regfile_if;
   import rat_regfile_pkg::*;

   logic  write_rat;
   areg_t issue_dest;
   tag_t  issue_tag;
   logic  commit1;
   areg_t commit_addr;
   data_t commit_val;
   tag_t  commit_tag;
   logic  commit2;
   areg_t commit_addr2;
   data_t commit_val2;
   tag_t  commit_tag2;
   logic  flush;
   areg_t rs_addr;
   areg_t rt_addr;
   data_t rs_val;
   data_t rt_val;
   tag_t  rs_tag;
   tag_t  rt_tag;
   logic  rs_ready;
   logic  rt_ready;

   modport master (
      output write_rat, issue_dest, issue_tag,
      output commit1, commit_addr, commit_val, commit_tag,
      output commit2, commit_addr2, commit_val2, commit_tag2,
      output flush, rs_addr, rt_addr,
      input  rs_val, rt_val, rs_tag, rt_tag, rs_ready, rt_ready
   );

   modport slave (
      input  write_rat, issue_dest, issue_tag,
      input  commit1, commit_addr, commit_val, commit_tag,
      input  commit2, commit_addr2, commit_val2, commit_tag2,
      input  flush, rs_addr, rt_addr,
      output rs_val, rt_val, rs_tag, rt_tag, rs_ready, rt_ready
   );

endinterface

// File: rtl/rat_regfile_read_port.sv
// One source-operand lookup: committed value, same-cycle commit bypass, or pending ROB tag.
module rat_regfile_read_port
   import rat_regfile_pkg::*;
(
   input  areg_t      addr_i,
   input  rat_entry_t entry_i,
   input  data_t      reg_val_i,
   input  logic       commit1_i,
   input  tag_t       commit_tag1_i,
   input  data_t      commit_val1_i,
   input  logic       commit2_i,
   input  tag_t       commit_tag2_i,
   input  data_t      commit_val2_i,
   output data_t      val_o,
   output tag_t       tag_o,
   output logic       ready_o
);

   always_comb begin
      val_o   = reg_val_i;
      tag_o   = '0;
      ready_o = 1'b1;
      if (addr_i == REG_ZERO) begin
         val_o = '0;
      end else if (!entry_i.busy) begin
         val_o = reg_val_i;
      end else if (commit2_i && (commit_tag2_i == entry_i.tag)) begin
         // younger commit checked first so it wins when both tags match
         val_o = commit_val2_i;
      end else if (commit1_i && (commit_tag1_i == entry_i.tag)) begin
         val_o = commit_val1_i;
      end else begin
         ready_o = 1'b0;
         tag_o   = entry_i.tag;
      end
   end

endmodule

// File: rtl/rat_regfile.sv
// Architectural register file fused with the register alias table (busy + ROB tag per register).
module rat_regfile
   import rat_regfile_pkg::*;
(
   input logic          clk,
   input logic          rst,
   rat_regfile_if.slave bus
);

   data_t      regs_q [NREG];
   data_t      regs_d [NREG];
   rat_entry_t ren_q  [NREG];
   rat_entry_t ren_d  [NREG];

   always_comb begin
      regs_d = regs_q;
      if (bus.commit1 && (bus.commit_addr != REG_ZERO)) begin
         regs_d[bus.commit_addr] = bus.commit_val;
      end
      if (bus.commit2 && (bus.commit_addr2 != REG_ZERO)) begin
         regs_d[bus.commit_addr2] = bus.commit_val2;
      end
   end

   // busy only drops when the committing tag is still the live mapping;
   // the issue rename is applied last so it overrides flush and commit clears
   always_comb begin
      ren_d = ren_q;
      for (int i = 0; i < NREG; i++) begin
         if (bus.flush) begin
            ren_d[i].busy = 1'b0;
         end else begin
            if (bus.commit1 && (bus.commit_addr == areg_t'(i)) &&
                ren_q[i].busy && (ren_q[i].tag == bus.commit_tag)) begin
               ren_d[i].busy = 1'b0;
            end
            if (bus.commit2 && (bus.commit_addr2 == areg_t'(i)) &&
                ren_q[i].busy && (ren_q[i].tag == bus.commit_tag2)) begin
               ren_d[i].busy = 1'b0;
            end
         end
      end
      if (bus.write_rat && (bus.issue_dest != REG_ZERO)) begin
         ren_d[bus.issue_dest].busy = 1'b1;
         ren_d[bus.issue_dest].tag  = bus.issue_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            ren_q[i]  <= '0;
         end
      end else begin
         regs_q <= regs_d;
         ren_q  <= ren_d;
      end
   end

   rat_regfile_read_port u_rs_port (
      .addr_i        (bus.rs_addr),
      .entry_i       (ren_q[bus.rs_addr]),
      .reg_val_i     (regs_q[bus.rs_addr]),
      .commit1_i     (bus.commit1),
      .commit_tag1_i (bus.commit_tag),
      .commit_val1_i (bus.commit_val),
      .commit2_i     (bus.commit2),
      .commit_tag2_i (bus.commit_tag2),
      .commit_val2_i (bus.commit_val2),
      .val_o         (bus.rs_val),
      .tag_o         (bus.rs_tag),
      .ready_o       (bus.rs_ready)
   );

   rat_regfile_read_port u_rt_port (
      .addr_i        (bus.rt_addr),
      .entry_i       (ren_q[bus.rt_addr]),
      .reg_val_i     (regs_q[bus.rt_addr]),
      .commit1_i     (bus.commit1),
      .commit_tag1_i (bus.commit_tag),
      .commit_val1_i (bus.commit_val),
      .commit2_i     (bus.commit2),
      .commit_tag2_i (bus.commit_tag2),
      .commit_val2_i (bus.commit_val2),
      .val_o         (bus.rt_val),
      .tag_o         (bus.rt_tag),
      .ready_o       (bus.rt_ready)
   );

endmodule

// File: tb/tb_rat_regfile.sv
// Scenario bench for rat_regfile: expected reads are queued with the stimulus and drained on sampling.
module tb_rat_regfile;
   import rat_regfile_pkg::*;

   typedef struct {
      string name;
      bit    port;
      data_t val;
      logic  rdy;
      tag_t  tag;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   exp_t exp_q[$];
   exp_t e;
   exp_t o;

   rat_regfile_if bus ();

   rat_regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t obs(input bit port);
      exp_t r;
      r.name = "";
      r.port = port;
      r.val  = port ? bus.rt_val   : bus.rs_val;
      r.rdy  = port ? bus.rt_ready : bus.rs_ready;
      r.tag  = port ? bus.rt_tag   : bus.rs_tag;
      return r;
   endfunction

   task automatic push(input string n, input bit p, input data_t v, input logic r, input tag_t t);
      exp_t x;
      x.name = n; x.port = p; x.val = v; x.rdy = r; x.tag = t;
      exp_q.push_back(x);
   endtask

   task automatic idle();
      bus.write_rat = 1'b0; bus.commit1 = 1'b0; bus.commit2 = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      bus.issue_dest = '0; bus.issue_tag = '0;
      bus.commit_addr = '0; bus.commit_val = '0; bus.commit_tag = '0;
      bus.commit_addr2 = '0; bus.commit_val2 = '0; bus.commit_tag2 = '0;
      bus.rs_addr = 5'd5; bus.rt_addr = 5'd31;
      #1;
      push("reset_r5", 0, 32'h0, 1'b1, 5'd0);
      push("reset_r31", 1, 32'h0, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || o.val !== e.val || o.tag !== e.tag) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_r0();
      @(negedge clk); idle();
      bus.commit1 = 1'b1; bus.commit_addr = REG_ZERO; bus.commit_val = 32'hFFFF; bus.commit_tag = 5'd0;
      bus.write_rat = 1'b1; bus.issue_dest = REG_ZERO; bus.issue_tag = 5'd3;
      @(negedge clk); idle();
      bus.rs_addr = REG_ZERO; bus.rt_addr = REG_ZERO;
      #1;
      push("r0_rs", 0, 32'h0, 1'b1, 5'd0);
      push("r0_rt", 1, 32'h0, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_rename_bypass();
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd3; bus.issue_tag = 5'd7;
      @(negedge clk); idle();
      bus.rs_addr = 5'd3;
      #1;
      push("r3_pending", 0, 32'h0, 1'b0, 5'd7);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      bus.commit1 = 1'b1; bus.commit_addr = 5'd3; bus.commit_val = 32'hAB; bus.commit_tag = 5'd7;
      #1;
      push("r3_bypass", 0, 32'hAB, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      @(negedge clk); idle();
      #1;
      push("r3_committed", 0, 32'hAB, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_younger_rename();
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd4; bus.issue_tag = 5'd2;
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd4; bus.issue_tag = 5'd9;
      @(negedge clk); idle();
      bus.commit1 = 1'b1; bus.commit_addr = 5'd4; bus.commit_val = 32'h11; bus.commit_tag = 5'd2;
      bus.rs_addr = 5'd4;
      #1;
      push("r4_stale_commit_no_bypass", 0, 32'h0, 1'b0, 5'd9);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      @(negedge clk); idle();
      #1;
      push("r4_still_busy", 0, 32'h0, 1'b0, 5'd9);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      bus.flush = 1'b1;
      @(negedge clk); idle();
      #1;
      push("r4_value_after_flush", 0, 32'h11, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_dual_commit();
      @(negedge clk); idle();
      bus.commit1 = 1'b1; bus.commit_addr  = 5'd6; bus.commit_val  = 32'h1; bus.commit_tag  = 5'd1;
      bus.commit2 = 1'b1; bus.commit_addr2 = 5'd6; bus.commit_val2 = 32'h2; bus.commit_tag2 = 5'd3;
      bus.write_rat = 1'b1; bus.issue_dest = 5'd7; bus.issue_tag = 5'd5;
      @(negedge clk); idle();
      bus.rs_addr = 5'd6; bus.rt_addr = 5'd7;
      bus.commit1 = 1'b1; bus.commit_addr  = 5'd7; bus.commit_val  = 32'h70; bus.commit_tag  = 5'd5;
      bus.commit2 = 1'b1; bus.commit_addr2 = 5'd7; bus.commit_val2 = 32'h71; bus.commit_tag2 = 5'd5;
      #1;
      push("r6_commit2_wins", 0, 32'h2, 1'b1, 5'd0);
      push("r7_bypass_commit2_wins", 1, 32'h71, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      @(negedge clk); idle();
      #1;
      push("r7_committed", 1, 32'h71, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_issue_commit_same();
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd8; bus.issue_tag = 5'd4;
      bus.commit1 = 1'b1; bus.commit_addr = 5'd8; bus.commit_val = 32'h55; bus.commit_tag = 5'd4;
      @(negedge clk); idle();
      bus.rs_addr = 5'd8;
      #1;
      push("r8_issue_wins", 0, 32'h0, 1'b0, 5'd4);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      bus.flush = 1'b1;
      @(negedge clk); idle();
      #1;
      push("r8_regs_written", 0, 32'h55, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_all_three();
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd9; bus.issue_tag = 5'd6;
      @(negedge clk); idle();
      bus.commit1 = 1'b1; bus.commit_addr  = 5'd9; bus.commit_val  = 32'h91; bus.commit_tag  = 5'd6;
      bus.commit2 = 1'b1; bus.commit_addr2 = 5'd9; bus.commit_val2 = 32'h92; bus.commit_tag2 = 5'd20;
      bus.write_rat = 1'b1; bus.issue_dest = 5'd9; bus.issue_tag = 5'd10;
      bus.rs_addr = 5'd9;
      #1;
      push("r9_bypass_commit1", 0, 32'h91, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      @(negedge clk); idle();
      #1;
      push("r9_rename_takes_issue", 0, 32'h0, 1'b0, 5'd10);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      bus.flush = 1'b1;
      @(negedge clk); idle();
      #1;
      push("r9_rf_gets_commit2", 0, 32'h92, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_flush();
      @(negedge clk); idle();
      bus.commit1 = 1'b1; bus.commit_addr = 5'd10; bus.commit_val = 32'hA0; bus.commit_tag = 5'd0;
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd10; bus.issue_tag = 5'd12;
      @(negedge clk); idle();
      bus.rs_addr = 5'd10;
      #1;
      push("r10_pending", 0, 32'h0, 1'b0, 5'd12);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      bus.flush = 1'b1;
      bus.write_rat = 1'b1; bus.issue_dest = 5'd11; bus.issue_tag = 5'd13;
      @(negedge clk); idle();
      bus.rt_addr = 5'd11;
      #1;
      push("r10_after_flush", 0, 32'hA0, 1'b1, 5'd0);
      push("r11_issue_survives_flush", 1, 32'h0, 1'b0, 5'd13);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); idle();
      bus.write_rat = 1'b1; bus.issue_dest = 5'd12; bus.issue_tag = 5'd1;
      @(negedge clk); idle();
      bus.rs_addr = 5'd12; bus.rt_addr = 5'd10;
      #1;
      push("r12_pending_pre_reset", 0, 32'h0, 1'b0, 5'd1);
      push("r10_pre_reset", 1, 32'hA0, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || (e.rdy ? o.val !== e.val : o.tag !== e.tag)) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      rst = 1'b0;
      #1;
      push("r12_async_reset", 0, 32'h0, 1'b1, 5'd0);
      push("r10_async_reset", 1, 32'h0, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || o.val !== e.val || o.tag !== e.tag) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      #1;
      push("r12_after_release", 0, 32'h0, 1'b1, 5'd0);
      push("r10_after_release", 1, 32'h0, 1'b1, 5'd0);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs(e.port); checks++;
         if (o.rdy !== e.rdy || o.val !== e.val || o.tag !== e.tag) begin
            errors++;
            $display("FAIL %s: got val=%h rdy=%b tag=%0d, want val=%h rdy=%b tag=%0d", e.name, o.val, o.rdy, o.tag, e.val, e.rdy, e.tag);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_r0();
      test_rename_bypass();
      test_younger_rename();
      test_dual_commit();
      test_issue_commit_same();
      test_all_three();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
